// File: rtl/master_pkg.sv
// Shared definitions for the stream generator: data-pattern mode codes,
// FSM state encoding and the LFSR feedback taps with a helper to advance it.
package master_pkg;

    localparam logic [1:0] MODE_RAMP = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_IDX  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Taps 32,22,2,1 expressed as bit positions 31,21,1,0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/master_pat_gen.sv
// Beat data pattern source. Holds the beat index (wraps at SEQ_LEN) and the
// 32-bit LFSR; both step once per accepted beat and return to their start
// values on restart or reset. The data word is formed from them per mode.
// Ports:
//   clk, RSTn   clock, synchronous active-low reset
//   i_advance   step index and LFSR (a beat was transferred)
//   i_restart   index to 0, LFSR to LFSR_SEED (new burst)
//   i_mode      pattern select (ramp / LFSR / index / all ones)
//   o_data      current beat data word
module master_pat_gen
    import master_pkg::*;
#(
    parameter int          DATA_W    = 24,
    parameter int          SEQ_LEN   = 6,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
)(
    input  logic              clk,
    input  logic              RSTn,
    input  logic              i_advance,
    input  logic              i_restart,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_data
);

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int N_LANE = DATA_W / 8;

    logic [IDX_W-1:0]  r_idx;
    logic [31:0]       r_lfsr;
    logic [7:0]        w_idx8;
    logic [DATA_W-1:0] w_data;

    always_ff @(posedge clk) begin
        if (!RSTn || i_restart) begin
            r_idx  <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (i_advance) begin
            r_idx  <= (r_idx == IDX_W'(SEQ_LEN - 1)) ? '0 : r_idx + IDX_W'(1);
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign w_idx8 = 8'(r_idx);

    always_comb begin
        w_data = '1;
        case (i_mode)
            MODE_RAMP: begin
                // Lane 0 is the most significant byte; 8-bit product wraps mod 256.
                for (int j = 0; j < N_LANE; j++) begin
                    w_data[DATA_W-1-8*j -: 8] = (w_idx8 + 8'(j)) * 8'h11;
                end
            end
            MODE_LFSR: begin
                // LFSR replicated upward for widths above 32, low bits otherwise.
                for (int b = 0; b < DATA_W; b++) begin
                    w_data[b] = r_lfsr[b % 32];
                end
            end
            MODE_IDX:  w_data = DATA_W'(r_idx);
            default:   w_data = '1;
        endcase
    end

    assign o_data = w_data;

endmodule

// File: rtl/master_stream_gen.sv
// Valid/ready stimulus source. Emits bursts (or a continuous stream) of
// pattern words with a last-beat flag, optional idle gaps after each beat,
// and a done pulse after a finite burst completes.
// Ports:
//   clk, RSTn       clock, synchronous active-low reset
//   master_en       run enable; dropping it ends the stream at a beat boundary
//   start           burst start pulse, honoured only when idle
//   mode, burst_len, gap_cycles   configuration, captured at start
//   master_valid, master_data, master_last   beat output
//   bus_ready       downstream accept
//   busy, done, beat_cnt          status
//
// state | meaning
// IDLE  | waiting for start with master_en high
// SEND  | beat presented, held until bus_ready
// GAP   | valid low, counting down the inter-beat gap
module master_stream_gen
    import master_pkg::*;
#(
    parameter int          DATA_W    = 24,
    parameter int          SEQ_LEN   = 6,
    parameter int          LEN_W     = 8,
    parameter int          GAP_W     = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
)(
    input  logic              clk,
    input  logic              RSTn,
    input  logic              master_en,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [GAP_W-1:0]  gap_cycles,
    output logic              master_valid,
    input  logic              bus_ready,
    output logic [DATA_W-1:0] master_data,
    output logic              master_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_mode;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_done;
    logic              w_start_ok;
    logic              w_xfer;
    logic              w_final;

    assign w_start_ok = (r_state == IDLE) && start && master_en;
    assign w_xfer     = (r_state == SEND) && bus_ready;
    // burst_len 0 means continuous, so no beat is ever final.
    assign w_final    = (r_len != '0) && (r_beat_cnt == r_len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!RSTn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start && master_en) w_state_nxt = SEND;
            SEND: begin
                // A pending beat is never dropped: master_en only acts after transfer.
                if (w_xfer) begin
                    if (w_final || !master_en) w_state_nxt = IDLE;
                    else if (r_gap != '0)      w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (!master_en)                    w_state_nxt = IDLE;
                else if (r_gap_cnt == GAP_W'(1))   w_state_nxt = SEND;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_mode     <= MODE_RAMP;
            r_len      <= '0;
            r_gap      <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_xfer && w_final;
            if (w_start_ok) begin
                r_mode     <= mode;
                r_len      <= burst_len;
                r_gap      <= gap_cycles;
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
            // Down-counter loaded on every transfer; only consumed in GAP.
            if (w_xfer)                r_gap_cnt <= r_gap;
            else if (r_state == GAP)   r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    master_pat_gen #(
        .DATA_W    (DATA_W),
        .SEQ_LEN   (SEQ_LEN),
        .LFSR_SEED (LFSR_SEED)
    ) u_pat (
        .clk       (clk),
        .RSTn      (RSTn),
        .i_advance (w_xfer),
        .i_restart (w_start_ok),
        .i_mode    (r_mode),
        .o_data    (master_data)
    );

    assign master_valid = (r_state == SEND);
    assign master_last  = master_valid && w_final;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign beat_cnt     = r_beat_cnt;

endmodule

// File: tb/tb_master_stream_gen.sv
module tb_master_stream_gen;

    localparam int          DATA_W  = 24;
    localparam int          SEQ_LEN = 6;
    localparam int          LEN_W   = 8;
    localparam int          GAP_W   = 4;
    localparam logic [31:0] SEED    = 32'hACE1_0001;

    logic              clk = 1'b0;
    logic              RSTn = 1'b0;
    logic              master_en = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic [GAP_W-1:0]  gap_cycles = '0;
    logic              bus_ready = 1'b0;
    logic              master_valid;
    logic [DATA_W-1:0] master_data;
    logic              master_last;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    master_stream_gen #(
        .DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .LEN_W(LEN_W), .GAP_W(GAP_W), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .RSTn(RSTn), .master_en(master_en), .start(start), .mode(mode),
        .burst_len(burst_len), .gap_cycles(gap_cycles), .master_valid(master_valid),
        .bus_ready(bus_ready), .master_data(master_data), .master_last(master_last),
        .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    // ---------------- reference model (burst-level view) ----------------
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [DATA_W-1:0] ref_pat(input logic [1:0] md, input int idx,
                                                 input logic [31:0] lf);
        logic [DATA_W-1:0] d;
        d = '1;
        case (md)
            2'd0: for (int j = 0; j < DATA_W/8; j++)
                      d[DATA_W-1-8*j -: 8] = 8'(((idx + j) * 17) % 256);
            2'd1: for (int b = 0; b < DATA_W; b++) d[b] = lf[b % 32];
            2'd2: d = DATA_W'(idx);
            default: d = '1;
        endcase
        return d;
    endfunction

    bit          m_act = 0;
    int          m_k = 0;
    int          m_gl = 0;
    bit          m_done = 0;
    logic [1:0]  m_mode = 0;
    int          m_len = 0;
    int          m_gap = 0;
    logic [31:0] m_lfsr = SEED;

    logic              e_valid, e_busy, e_done, e_last;
    logic [DATA_W-1:0] e_data;
    logic [LEN_W-1:0]  e_cnt;

    bit chk_en = 0;
    int cyc_n = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int tot_xfer = 0;
    logic [DATA_W-1:0] xq[$];
    bit                lq[$];
    int                tq[$];

    logic              p_valid = 0, p_ready = 0, p_last = 0;
    logic [DATA_W-1:0] p_data = '0;

    always @(negedge clk) begin
        bit fin;
        cyc_n++;
        if (chk_en) begin
            n_tests++;
            if (master_valid !== e_valid || busy !== e_busy || done !== e_done ||
                beat_cnt !== e_cnt || (e_valid && master_data !== e_data) ||
                master_last !== e_last) begin
                n_fail++;
                $display("FAIL cycle %0d: got v=%b b=%b d=%b cnt=%0d data=%h last=%b, want v=%b b=%b d=%b cnt=%0d data=%h last=%b",
                         cyc_n, master_valid, busy, done, beat_cnt, master_data, master_last,
                         e_valid, e_busy, e_done, e_cnt, e_data, e_last);
            end
            if (p_valid && !p_ready && RSTn) begin
                n_tests++;
                if (master_valid !== 1'b1 || master_data !== p_data || master_last !== p_last) begin
                    n_fail++;
                    $display("FAIL hold cycle %0d: got v=%b data=%h last=%b, want v=1 data=%h last=%b",
                             cyc_n, master_valid, master_data, master_last, p_data, p_last);
                end
            end
        end
        if (RSTn && master_valid === 1'b1 && bus_ready) begin
            xq.push_back(master_data);
            lq.push_back(master_last);
            tq.push_back(cyc_n);
            tot_xfer++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        p_valid = master_valid; p_ready = bus_ready; p_data = master_data; p_last = master_last;

        // predict the next cycle from the inputs that will be sampled at the coming edge
        if (!RSTn) begin
            m_act = 0; m_k = 0; m_gl = 0; m_done = 0; m_lfsr = SEED; m_mode = 0;
            p_valid = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (start && master_en) begin
                    m_act = 1; m_k = 0; m_gl = 0; m_lfsr = SEED;
                    m_mode = mode; m_len = int'(burst_len); m_gap = int'(gap_cycles);
                end
            end else if (m_gl > 0) begin
                if (!master_en) m_act = 0;
                else            m_gl--;
            end else if (bus_ready) begin
                fin = (m_len != 0) && (m_k == m_len - 1);
                m_k++;
                m_lfsr = ref_step(m_lfsr);
                if (fin)             begin m_act = 0; m_done = 1; end
                else if (!master_en) m_act = 0;
                else                 m_gl = m_gap;
            end
        end
        e_valid = m_act && (m_gl == 0);
        e_busy  = m_act;
        e_done  = m_done;
        e_cnt   = LEN_W'(m_k % (1 << LEN_W));
        e_last  = e_valid && (m_len != 0) && (m_k == m_len - 1);
        e_data  = ref_pat(m_mode, m_k % SEQ_LEN, m_lfsr);
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clr();
        xq.delete(); lq.delete(); tq.delete();
    endtask

    task automatic go(input logic [1:0] md, input int len, input int gap);
        mode = md; burst_len = LEN_W'(len); gap_cycles = GAP_W'(gap);
        master_en = 1; start = 1;
        cyc(1);
        start = 0;
    endtask

    task automatic wait_xq(input int n, input string nm);
        int c;
        c = 0;
        while (xq.size() < n && c < 40) begin cyc(1); c++; end
        chk(nm, 64'(xq.size() >= n), 64'd1);
    endtask

    logic [DATA_W-1:0] ramp_lit [8];
    logic [DATA_W-1:0] sv0, sv1;
    int d0, nl;

    initial begin
        ramp_lit[0] = 24'h001122; ramp_lit[1] = 24'h112233; ramp_lit[2] = 24'h223344;
        ramp_lit[3] = 24'h334455; ramp_lit[4] = 24'h445566; ramp_lit[5] = 24'h556677;
        ramp_lit[6] = 24'h001122; ramp_lit[7] = 24'h112233;

        // 1: reset
        RSTn = 0;
        cyc(1);
        chk_en = 1;
        cyc(1);
        chk("rst_valid", 64'(master_valid), 0);
        chk("rst_last",  64'(master_last), 0);
        chk("rst_busy",  64'(busy), 0);
        chk("rst_done",  64'(done), 0);
        chk("rst_cnt",   64'(beat_cnt), 0);
        RSTn = 1;
        cyc(2);

        // 2: ramp burst of 8 back-to-back
        bus_ready = 1; clr(); d0 = done_cnt;
        go(2'd0, 8, 0);
        cyc(14);
        chk("t2_beats", 64'(xq.size()), 8);
        nl = 0;
        for (int i = 0; i < 8 && i < xq.size(); i++) begin
            chk($sformatf("t2_data%0d", i), 64'(xq[i]), 64'(ramp_lit[i]));
            nl += lq[i];
        end
        chk("t2_last_beat8", 64'(lq.size() == 8 && lq[7]), 1);
        chk("t2_last_count", 64'(nl), 1);
        chk("t2_done_count", 64'(done_cnt - d0), 1);
        if (tq.size() == 8) chk("t2_done_latency", 64'(done_cyc - tq[7]), 1);
        chk("t2_busy", 64'(busy), 0);

        // 3: backpressure on beat 3
        clr(); d0 = done_cnt;
        go(2'd0, 6, 0);
        wait_xq(2, "t3_wait2");
        bus_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t3_hold_valid", 64'(master_valid), 1);
            chk("t3_hold_data", 64'(master_data), 64'h223344);
        end
        bus_ready = 1;
        cyc(10);
        chk("t3_beats", 64'(xq.size()), 6);
        for (int i = 0; i < 6 && i < xq.size(); i++)
            chk($sformatf("t3_data%0d", i), 64'(xq[i]), 64'(ramp_lit[i]));
        chk("t3_done_count", 64'(done_cnt - d0), 1);

        // 4: gaps of 3, index mode
        clr(); d0 = done_cnt;
        go(2'd2, 3, 3);
        cyc(20);
        chk("t4_beats", 64'(xq.size()), 3);
        if (tq.size() == 3) begin
            chk("t4_gap01", 64'(tq[1] - tq[0] - 1), 3);
            chk("t4_gap12", 64'(tq[2] - tq[1] - 1), 3);
            chk("t4_data2", 64'(xq[2]), 2);
            chk("t4_last", 64'({lq[0], lq[1], lq[2]}), 64'b001);
        end
        chk("t4_done_count", 64'(done_cnt - d0), 1);

        // 5: continuous index stream, stop with a pending beat
        clr(); d0 = done_cnt;
        go(2'd2, 0, 0);
        wait_xq(8, "t5_wait8");
        bus_ready = 0; master_en = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t5_pending_valid", 64'(master_valid), 1);
            chk("t5_pending_data", 64'(master_data), 2);
        end
        bus_ready = 1;
        cyc(3);
        chk("t5_beats", 64'(xq.size()), 9);
        for (int i = 0; i < xq.size(); i++) begin
            chk($sformatf("t5_idx%0d", i), 64'(xq[i]), 64'(i % SEQ_LEN));
            chk("t5_no_last", 64'(lq[i]), 0);
        end
        chk("t5_no_done", 64'(done_cnt - d0), 0);
        chk("t5_busy", 64'(busy), 0);

        // 6: LFSR, reset mid-burst, restart
        clr(); d0 = done_cnt;
        go(2'd1, 10, 1);
        wait_xq(4, "t6_wait4");
        if (xq.size() >= 2) begin
            chk("t6_lfsr0", 64'(xq[0]), 64'h00E10001);
            chk("t6_lfsr1", 64'(xq[1]), 64'h00C20003);
            sv0 = xq[0]; sv1 = xq[1];
        end
        RSTn = 0;
        cyc(1);
        chk("t6_rst_valid", 64'(master_valid), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        RSTn = 1;
        cyc(2);
        chk("t6_no_done", 64'(done_cnt - d0), 0);
        clr();
        go(2'd1, 10, 1);
        wait_xq(2, "t6_wait_restart");
        if (xq.size() >= 2) begin
            chk("t6_repeat0", 64'(xq[0]), 64'(sv0));
            chk("t6_repeat1", 64'(xq[1]), 64'(sv1));
        end
        cyc(30);

        // random bursts against the model
        d0 = tot_xfer;
        for (int it = 0; it < 40; it++) begin
            go(2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)),
               int'($urandom_range(0, 3)));
            for (int c = 0, n = int'($urandom_range(10, 60)); c < n; c++) begin
                bus_ready = ($urandom_range(0, 9) < 7);
                master_en = ($urandom_range(0, 29) != 0);
                start     = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    mode       = 2'($urandom_range(0, 3));
                    burst_len  = LEN_W'($urandom_range(0, 12));
                    gap_cycles = GAP_W'($urandom_range(0, 3));
                end
                RSTn = ($urandom_range(0, 49) != 0);
                cyc(1);
            end
            RSTn = 1; start = 0; master_en = 0; bus_ready = 1;
            cyc(20);
            chk("rand_idle", 64'(busy), 0);
        end
        n_tests++;
        if (tot_xfer - d0 < 50) begin
            n_fail++;
            $display("FAIL rand_activity: got %0d transfers want at least 50", tot_xfer - d0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
